layer_sequencer: RTL and testbench

- Top-level scheduler for the conv accelerator.
- Walks a small per-layer configuration table. For each layer it restarts and enables weight_fill_control and the input-data fill block in parallel, waits for both done flags, then runs the systolic compute stage until compute done.
- Re-arms sub-blocks with a one-cycle active-low reset pulse, because their done flags stay high until reset.
- Sits between the host/config interface and the fill/compute datapath.

---
 rtl/layer_sequencer_pkg.sv | 32 +++
 rtl/layer_cfg_table.sv | 26 ++
 rtl/layer_sequencer.sv | 173 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the conv-accelerator layer sequencer:
// FSM encodings, watchdog width and the packed config-record width.
package layer_sequencer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_FILL    = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_NEXT    = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    LOAD    = ST_LOAD,
    FILL    = ST_FILL,
    COMPUTE = ST_COMPUTE,
    NEXT    = ST_NEXT,
    FINISH  = ST_FINISH
  } seq_state_t;

  localparam int WDOG_W = 20;

  // A config record is {weight_addr, weight_size, num_filters}.
  function automatic int cfg_rec_w(input int addr_w, input int dim_w);
    return addr_w + 2 * dim_w;
  endfunction

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DIM_W  = 16;
  localparam int CFG_REC_W  = cfg_rec_w(DEF_ADDR_W, DEF_DIM_W);

endpackage

// File: rtl/layer_cfg_table.sv
// Per-layer configuration register file: one synchronous write port,
// one asynchronous read port addressed by the layer in progress.
module layer_cfg_table #(
  parameter int idx_w = 2,
  parameter int rec_w = 46
) (
  input  logic             clk,
  input  logic             we,
  input  logic [idx_w-1:0] widx,
  input  logic [rec_w-1:0] wdata,
  input  logic [idx_w-1:0] ridx,
  output logic [rec_w-1:0] rdata
);

  // NOTE: the storage array has no reset; the host must write every entry
  // it intends to run, and contents survive a sequencer reset.
  logic [rec_w-1:0] mem [2**idx_w];

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/layer_sequencer.sv
// Layer scheduler: per layer, restart + run weight/data fill in parallel,
// then compute. Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int dim_data_size = 16,
  parameter int addr_width    = 14,
  parameter int layer_idx_w   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [layer_idx_w-1:0]   cfg_idx,
  input  logic [addr_width-1:0]    cfg_weight_addr,
  input  logic [dim_data_size-1:0] cfg_weight_size,
  input  logic [dim_data_size-1:0] cfg_num_filters,
  input  logic [layer_idx_w:0]     layer_count,
  input  logic                     start,
  output logic                     wf_reset_n,
  output logic                     wf_enable,
  output logic [addr_width-1:0]    wf_initial_address,
  output logic [dim_data_size-1:0] wf_weight_size,
  output logic [dim_data_size-1:0] wf_number_filters,
  input  logic                     wf_done,
  output logic                     df_reset_n,
  output logic                     df_enable,
  input  logic                     df_done,
  output logic                     comp_enable,
  input  logic                     comp_done,
  output logic [layer_idx_w-1:0]   cur_layer,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int REC_W = cfg_rec_w(addr_width, dim_data_size);
  localparam int CNT_W = layer_idx_w + 1;

  seq_state_t             state, next_state;
  logic [layer_idx_w-1:0] cur_layer_n;
  logic                   wf_seen, df_seen, wf_seen_n, df_seen_n;
  logic                   sub_reset_n;
  logic                   last_layer;
  logic                   timeout;
  logic                   tbl_we;
  logic [REC_W-1:0]       rd_rec;

  // The table is frozen while a run is in flight.
  assign tbl_we = cfg_we && (state == IDLE || state == FINISH);

  layer_cfg_table #(
    .idx_w (layer_idx_w),
    .rec_w (REC_W)
  ) u_cfg_table (
    .clk   (clk),
    .we    (tbl_we),
    .widx  (cfg_idx),
    .wdata ({cfg_weight_addr, cfg_weight_size, cfg_num_filters}),
    .ridx  (cur_layer),
    .rdata (rd_rec)
  );

  assign last_layer = ({1'b0, cur_layer} == layer_count - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every variable written here gets a default first, so no latch
  // can be inferred on any path through the case statement.
  always_comb begin
    next_state  = state;
    cur_layer_n = cur_layer;
    wf_seen_n   = wf_seen;
    df_seen_n   = df_seen;
    unique case (state)
      IDLE: begin
        if (start) begin
          cur_layer_n = '0;
          next_state  = (layer_count == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        wf_seen_n  = 1'b0;
        df_seen_n  = 1'b0;
        next_state = FILL;
      end
      FILL: begin
        wf_seen_n = wf_seen | wf_done;
        df_seen_n = df_seen | df_done;
        if (wf_seen_n && df_seen_n) next_state = COMPUTE;
      end
      COMPUTE: begin
        if (comp_done) next_state = NEXT;
      end
      NEXT: begin
        if (last_layer) begin
          next_state = FINISH;
        end else begin
          cur_layer_n = cur_layer + layer_idx_w'(1);
          next_state  = LOAD;
        end
      end
      FINISH: begin
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (timeout) next_state = FINISH;
  end

  // Control outputs are registered from the next state so they change
  // cleanly on the edge that enters each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_layer          <= '0;
      wf_seen            <= 1'b0;
      df_seen            <= 1'b0;
      sub_reset_n        <= 1'b0;
      wf_enable          <= 1'b0;
      df_enable          <= 1'b0;
      comp_enable        <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      wf_initial_address <= '0;
      wf_weight_size     <= '0;
      wf_number_filters  <= '0;
    end else begin
      cur_layer   <= cur_layer_n;
      wf_seen     <= wf_seen_n;
      df_seen     <= df_seen_n;
      sub_reset_n <= !(next_state inside {IDLE, LOAD});
      wf_enable   <= (next_state == FILL) && !wf_seen_n;
      df_enable   <= (next_state == FILL) && !df_seen_n;
      comp_enable <= (next_state == COMPUTE);
      busy        <= !(next_state inside {IDLE, FINISH});
      done        <= (next_state == FINISH);
      if (state == LOAD) begin
        {wf_initial_address, wf_weight_size, wf_number_filters} <= rd_rec;
      end
    end
  end

  assign wf_reset_n = sub_reset_n;
  assign df_reset_n = sub_reset_n;

`ifdef SEQ_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;
  logic              error_q;

  assign timeout = (state == FILL || state == COMPUTE) && (wdog == '1);

  // Restarts on every state change; only advances while waiting on a sub-block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog    <= '0;
      error_q <= 1'b0;
    end else begin
      if (next_state != state)                    wdog <= '0;
      else if (state == FILL || state == COMPUTE) wdog <= wdog + WDOG_W'(1);
      if (timeout)                                error_q <= 1'b1;
      else if (state == IDLE && start)            error_q <= 1'b0;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: a phase-level trace model checked
// every cycle, reactive fill/compute responders, and literal spot checks.
module tb_layer_sequencer;

  localparam int DW    = 16;
  localparam int AW    = 14;
  localparam int IW    = 2;
  localparam int CW    = IW + 1;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          wrn, drn, wen, den, cen, busy, done, err;
    logic [IW-1:0] layer;
    logic [AW-1:0] addr;
    logic [DW-1:0] size, filt;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_weight_addr;
  logic [DW-1:0] cfg_weight_size, cfg_num_filters;
  logic [IW:0]   layer_count;
  logic          start;
  logic          wf_reset_n, wf_enable, wf_done;
  logic [AW-1:0] wf_initial_address;
  logic [DW-1:0] wf_weight_size, wf_number_filters;
  logic          df_reset_n, df_enable, df_done;
  logic          comp_enable, comp_done;
  logic [IW-1:0] cur_layer;
  logic          busy, done, error;

  always #5 clk = ~clk;

  layer_sequencer #(
    .dim_data_size (DW),
    .addr_width    (AW),
    .layer_idx_w   (IW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_we             (cfg_we),
    .cfg_idx            (cfg_idx),
    .cfg_weight_addr    (cfg_weight_addr),
    .cfg_weight_size    (cfg_weight_size),
    .cfg_num_filters    (cfg_num_filters),
    .layer_count        (layer_count),
    .start              (start),
    .wf_reset_n         (wf_reset_n),
    .wf_enable          (wf_enable),
    .wf_initial_address (wf_initial_address),
    .wf_weight_size     (wf_weight_size),
    .wf_number_filters  (wf_number_filters),
    .wf_done            (wf_done),
    .df_reset_n         (df_reset_n),
    .df_enable          (df_enable),
    .df_done            (df_done),
    .comp_enable        (comp_enable),
    .comp_done          (comp_done),
    .cur_layer          (cur_layer),
    .busy               (busy),
    .done               (done),
    .error              (error)
  );

  // Model state: table as written by the host, config currently on the outputs,
  // per-layer sub-block latencies, and the expected per-cycle trace.
  logic [AW-1:0] m_addr [DEPTH];
  logic [DW-1:0] m_size [DEPTH];
  logic [DW-1:0] m_filt [DEPTH];
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_size = '0;
  logic [DW-1:0] cur_filt = '0;
  int            lat_w [DEPTH];
  int            lat_d [DEPTH];
  int            lat_c [DEPTH];
  obs_t          exp_q [$];

  int n_checks = 0;
  int n_err    = 0;
  int cnt_wen = 0, cnt_den = 0, cnt_cen = 0, cnt_busy = 0, cnt_load = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.wrn = wf_reset_n;  o.drn = df_reset_n;
    o.wen = wf_enable;   o.den = df_enable;  o.cen = comp_enable;
    o.busy = busy;       o.done = done;      o.err = error;
    o.layer = cur_layer;
    o.addr = wf_initial_address; o.size = wf_weight_size; o.filt = wf_number_filters;
    return o;
  endfunction

  task automatic push(input logic rn, input logic wen, input logic den, input logic cen,
                      input logic bsy, input logic dn, input int layer);
    obs_t e;
    e.wrn = rn;  e.drn = rn;  e.wen = wen;  e.den = den;  e.cen = cen;
    e.busy = bsy; e.done = dn; e.err = 1'b0;
    e.layer = IW'(layer);
    e.addr = cur_addr; e.size = cur_size; e.filt = cur_filt;
    exp_q.push_back(e);
  endtask

  // Phase-level model: LOAD 1, FILL max(w,d), COMPUTE c, NEXT 1 per layer,
  // then two FINISH cycles (start held) and one IDLE. recs excludes the IDLE.
  task automatic build_run(input int n, output int recs);
    int f;
    int last;
    recs = 0;
    for (int l = 0; l < n; l++) begin
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, l);
      cur_addr = m_addr[l]; cur_size = m_size[l]; cur_filt = m_filt[l];
      f = (lat_w[l] > lat_d[l]) ? lat_w[l] : lat_d[l];
      for (int c = 1; c <= f; c++) push(1'b1, c <= lat_w[l], c <= lat_d[l], 1'b0, 1'b1, 1'b0, l);
      for (int c = 1; c <= lat_c[l]; c++) push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, l);
      push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, l);
      recs += 2 + f + lat_c[l];
    end
    last = (n == 0) ? 0 : n - 1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last);
    recs += 2;
  endtask

  task automatic write_cfg(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] s,
                           input logic [DW-1:0] f, input bit track);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IW'(idx);
    cfg_weight_addr = a; cfg_weight_size = s; cfg_num_filters = f;
    @(negedge clk);
    cfg_we = 1'b0;
    if (track) begin
      m_addr[idx] = a; m_size[idx] = s; m_filt[idx] = f;
    end
  endtask

  task automatic set_lat(input int l, input int w, input int d, input int c);
    lat_w[l] = w; lat_d[l] = d; lat_c[l] = c;
  endtask

  task automatic do_run(input int n);
    int r;
    @(negedge clk);
    build_run(n, r);
    layer_count = CW'(n);
    start = 1'b1;
    repeat (r) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("trace_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Sub-block responders: each fill raises done after its enable has been seen
  // for its latency and holds it until restarted; compute drops done with enable.
  initial begin
    int wc, dc, cc;
    wc = 0; dc = 0; cc = 0;
    wf_done = 1'b0; df_done = 1'b0; comp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!wf_reset_n) begin wc = 0; wf_done = 1'b0; end
      else if (wf_enable) begin wc++; if (wc >= lat_w[cur_layer]) wf_done = 1'b1; end
      if (!df_reset_n) begin dc = 0; df_done = 1'b0; end
      else if (df_enable) begin dc++; if (dc >= lat_d[cur_layer]) df_done = 1'b1; end
      if (comp_enable) begin cc++; if (cc >= lat_c[cur_layer]) comp_done = 1'b1; end
      else begin cc = 0; comp_done = 1'b0; end
    end
  end

  // Compare process: one trace record per cycle while a run is scheduled.
  initial begin
    obs_t o, e;
    forever begin
      @(posedge clk);
      #1;
      o = observe();
      if (o.wen) cnt_wen++;
      if (o.den) cnt_den++;
      if (o.cen) cnt_cen++;
      if (o.busy) cnt_busy++;
      if (o.busy && !o.wrn) cnt_load++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", 64'(o), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    int b_wen, b_den, b_cen, b_busy, b_load, r;
    obs_t zero;
    zero = '0;
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; layer_count = '0;
    cfg_weight_addr = '0; cfg_weight_size = '0; cfg_num_filters = '0;
    for (int i = 0; i < DEPTH; i++) set_lat(i, 1, 1, 1);

    @(posedge clk); #1;
    check("reset_state", 64'(observe()), 64'(zero));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single layer, data fill finishes first.
    write_cfg(0, 14'h010, 16'd3, 16'd2, 1'b1);
    set_lat(0, 40, 25, 10);
    b_wen = cnt_wen; b_den = cnt_den; b_cen = cnt_cen; b_busy = cnt_busy;
    do_run(1);
    check("t1_wf_en_cycles", 64'(cnt_wen - b_wen), 64'd40);
    check("t1_df_en_cycles", 64'(cnt_den - b_den), 64'd25);
    check("t1_comp_cycles", 64'(cnt_cen - b_cen), 64'd10);
    check("t1_busy_cycles", 64'(cnt_busy - b_busy), 64'd52);
    check("t1_addr", 64'(wf_initial_address), 64'h010);
    check("t1_size", 64'(wf_weight_size), 64'd3);
    check("t1_filters", 64'(wf_number_filters), 64'd2);

    // Three layers with distinct entries and mixed latencies.
    write_cfg(0, 14'h100, 16'd5, 16'd7, 1'b1);
    write_cfg(1, 14'h2A5, 16'd1, 16'd16, 1'b1);
    write_cfg(2, 14'h3FFF, 16'hFFFF, 16'd1, 1'b1);
    set_lat(0, 3, 5, 4);
    set_lat(1, 6, 2, 3);
    set_lat(2, 1, 1, 1);
    b_load = cnt_load;
    do_run(3);
    check("t2_load_pulses", 64'(cnt_load - b_load), 64'd3);
    check("t2_addr", 64'(wf_initial_address), 64'h3FFF);
    check("t2_size", 64'(wf_weight_size), 64'hFFFF);

    // Zero layers: straight to FINISH, nothing enabled.
    b_wen = cnt_wen; b_den = cnt_den; b_cen = cnt_cen; b_busy = cnt_busy;
    do_run(0);
    check("t3_no_enables", 64'((cnt_wen - b_wen) + (cnt_den - b_den) + (cnt_cen - b_cen)), 64'd0);
    check("t3_never_busy", 64'(cnt_busy - b_busy), 64'd0);

    // Both fill dones in the same cycle.
    set_lat(0, 6, 6, 2);
    b_busy = cnt_busy;
    do_run(1);
    check("t4_busy_cycles", 64'(cnt_busy - b_busy), 64'd10);

    // Abort in COMPUTE of layer 1; a write while busy must be ignored.
    set_lat(0, 3, 4, 2);
    set_lat(1, 2, 2, 20);
    @(negedge clk);
    build_run(3, r);
    while (exp_q.size() > 14) void'(exp_q.pop_back());
    layer_count = CW'(3);
    start = 1'b1;
    @(negedge clk);
    write_cfg(1, 14'h1234, 16'd9, 16'd9, 1'b0);
    repeat (11) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    cur_addr = '0; cur_size = '0; cur_filt = '0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1;
    check("t5_abort_immediate", 64'(observe()), 64'(zero));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_trace_drained", 64'(exp_q.size()), 64'd0);

    // Table contents survive reset; rerun two layers.
    set_lat(1, 4, 3, 2);
    do_run(2);
    check("t6_addr", 64'(wf_initial_address), 64'h2A5);
    check("t6_filters", 64'(wf_number_filters), 64'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
